booth_r4_seq_mult: RTL and testbench

Sequential signed radix-4 Booth multiplier for the MACC datapath. It sits directly downstream of the 5-bit complement stage in the Radix-4 Booth encode path. Each cycle it recodes one overlapping multiplier triplet into a Booth digit in {-2, -1, 0, +1, +2}. It selects 0, ±A or ±2A, using the two's-complement negate of the sign-extended multiplicand for the negative digits, and accumulates the shifted partial products into a 2W-bit signed product. A start/busy/done handshake lets the MACC controller issue back-to-back multiplies.

---
 rtl/booth_r4_seq_mult.sv | 74 +++++++
 tb/tb_booth_r4_seq_mult.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential signed radix-4 Booth multiplier, one digit per cycle
module booth_r4_seq_mult #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);
    localparam int N  = W / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q, state_d;
    logic [2*W-1:0] a_q, a_d, acc_q, acc_d, p_q, p_d;
    logic [W-1:0]   b_q, b_d;
    logic [IW-1:0]  i_q, i_d;
    logic [W:0]     b_ext;
    logic [2:0]     trip;
    logic           accept, last, zero, two, neg;
    logic [2*W-1:0] mag, pp, sum;
    assign accept = start && (state_q != RUN);
    assign last   = (i_q == IW'(N - 1));
    assign b_ext  = {b_q, 1'b0};
    assign trip   = b_ext[{i_q, 1'b0} +: 3];
    assign zero   = (trip == 3'b000) || (trip == 3'b111);
    assign two    = (trip == 3'b011) || (trip == 3'b100);
    assign neg    = trip[2];
    assign mag    = two ? (a_q << 1) : a_q;
    assign pp     = zero ? '0 : (neg ? -mag : mag);
    assign sum    = acc_q + (pp << {i_q, 1'b0});
    assign p      = p_q;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Next state: accept from IDLE/DONE, leave RUN after the last digit, DONE lasts one cycle
    always_comb begin
        state_d = accept ? RUN : (state_q == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    // Handshake outputs decoded from state
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end
    // Datapath next state: latch operands on accept, accumulate one shifted partial product per RUN cycle
    always_comb begin
        a_d   = accept ? {{W{a[W-1]}}, a} : a_q;
        b_d   = accept ? b : b_q;
        acc_d = accept ? '0 : (state_q == RUN) ? sum : acc_q;
        i_d   = accept ? '0 : (state_q == RUN) ? i_q + 1'b1 : i_q;
        p_d   = (state_q == RUN && last) ? sum : p_q;
    end
    // Datapath registers, all cleared by reset so an aborted multiply leaves no trace
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            i_q   <= '0;
            p_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            i_q   <= i_d;
            p_q   <= p_d;
        end
    end
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: directed self-checking bench for the W=4 Booth multiplier
module tb_booth_r4_seq_mult;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy, done;
    logic [7:0] p;
    int n_vec = 0;
    int n_err = 0;

    booth_r4_seq_mult #(.W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .p(p)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mul(input string tag, input logic [3:0] aa, input logic [3:0] bb, input logic [7:0] exp);
        int cyc;
        a = aa;
        b = bb;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 10) begin
            tick;
            cyc++;
        end
        chk({tag, "_lat"}, 16'(cyc), 16'd3);
        chk(tag, 16'(p), 16'(exp));
    endtask

    initial begin
        logic signed [7:0] ref_p;
        logic [7:0] cap;
        int dones;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_p", 16'(p), 16'd0);

        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("t1_c1", {14'd0, busy, done}, 16'b10);
        tick;
        chk("t1_c2", {14'd0, busy, done}, 16'b10);
        tick;
        chk("t1_c3", {14'd0, busy, done}, 16'b01);
        chk("t1_p", 16'(p), 16'h0F);
        tick;
        chk("t1_c4", {14'd0, busy, done}, 16'b00);

        mul("m8m8", 4'h8, 4'h8, 8'h40);
        mul("m8p7", 4'h8, 4'h7, 8'hC8);
        mul("p7m8", 4'h7, 4'h8, 8'hC8);
        mul("z_m5", 4'h0, 4'hB, 8'h00);
        mul("m1m1", 4'hF, 4'hF, 8'h01);
        mul("p5m3", 4'h5, 4'hD, 8'hF1);
        mul("m7p6", 4'h9, 4'h6, 8'hD6);
        mul("p6p6", 4'h6, 4'h6, 8'h24);

        for (int k = 0; k < 256; k++) begin
            a = 4'(k >> 4);
            b = 4'(k);
            ref_p = $signed({{4{a[3]}}, a}) * $signed({{4{b[3]}}, b});
            start = 1'b1;
            tick;
            a = ~a;
            b = b + 4'd3;
            tick;
            tick;
            chk("sweep", {7'd0, done, p}, {7'd0, 1'b1, ref_p});
        end
        start = 1'b0;
        tick;

        a = 4'hD;
        b = 4'h5;
        start = 1'b1;
        tick;
        a = 4'h7;
        b = 4'h7;
        dones = 0;
        cap = '0;
        for (int c = 0; c < 7; c++) begin
            if (done) begin
                cap = p;
                start = 1'b0;
            end
            dones += 32'(done);
            tick;
        end
        chk("ign_dones", 16'(dones), 16'd1);
        chk("ign_p", 16'(cap), 16'hF1);

        a = 4'h5;
        b = 4'h5;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_st", {14'd0, busy, done}, 16'b00);
        chk("abort_p", 16'(p), 16'd0);
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            dones += 32'(done);
            tick;
        end
        chk("abort_nodone", 16'(dones), 16'd0);
        mul("p2m3", 4'h2, 4'hD, 8'hFA);

        for (int c = 0; c < 8; c++) begin
            tick;
            chk("hold", {6'd0, busy, done, p}, {6'd0, 2'b00, 8'hFA});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
